// File: rtl/counter_checker.sv
// Passive monitor for a free-running up-counter bus: locks onto the +1 sequence,
// pulses err on each break while locked, and keeps saturating error / wrap statistics.
module counter_checker #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned ERR_CNT_W  = 8,
  parameter int unsigned WRAP_CNT_W = 8,
  parameter int unsigned SYNC_LEN   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_stats,
  input  logic [WIDTH-1:0]      q_in,
  output logic                  locked,
  output logic                  err,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]      expected
);

  localparam int unsigned SYNC_W = $clog2(SYNC_LEN + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [WIDTH-1:0]      prev, prev_nxt;
  logic [SYNC_W-1:0]     sync_cnt, sync_cnt_nxt;
  logic                  locked_nxt, err_nxt;
  logic [ERR_CNT_W-1:0]  err_count_nxt, err_base;
  logic [WRAP_CNT_W-1:0] wrap_count_nxt, wrap_base;
  logic [WIDTH-1:0]      expected_nxt;
  logic [WIDTH-1:0]      prev_inc;
  logic [SYNC_W-1:0]     sync_inc;
  logic                  step_ok;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      prev       <= '0;
      sync_cnt   <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      expected   <= '0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      sync_cnt   <= sync_cnt_nxt;
      locked     <= locked_nxt;
      err        <= err_nxt;
      err_count  <= err_count_nxt;
      wrap_count <= wrap_count_nxt;
      expected   <= expected_nxt;
    end
  end

  // Next-state, statistics and output values
  always_comb begin
    state_nxt      = state;
    prev_nxt       = prev;
    sync_cnt_nxt   = sync_cnt;
    locked_nxt     = locked;
    err_nxt        = 1'b0;
    prev_inc       = prev + WIDTH'(1);
    sync_inc       = sync_cnt + SYNC_W'(1);
    step_ok        = (q_in == prev_inc);
    // Clear first so a same-cycle event lands on top of zero
    err_base       = clr_stats ? '0 : err_count;
    wrap_base      = clr_stats ? '0 : wrap_count;
    err_count_nxt  = err_base;
    wrap_count_nxt = wrap_base;

    if (!en) begin
      state_nxt  = ST_IDLE;
      locked_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          prev_nxt     = q_in;
          sync_cnt_nxt = '0;
          state_nxt    = ST_SYNC;
        end
        ST_SYNC: begin
          prev_nxt = q_in;
          if (step_ok) begin
            if (sync_inc == SYNC_W'(SYNC_LEN)) begin
              state_nxt    = ST_LOCKED;
              locked_nxt   = 1'b1;
              sync_cnt_nxt = '0;
            end else begin
              sync_cnt_nxt = sync_inc;
            end
          end else begin
            sync_cnt_nxt = '0;
          end
        end
        ST_LOCKED: begin
          prev_nxt = q_in;
          if (step_ok) begin
            if (prev == {WIDTH{1'b1}}) wrap_count_nxt = wrap_base + WRAP_CNT_W'(1);
          end else begin
            err_nxt = 1'b1;
            if (err_base != {ERR_CNT_W{1'b1}}) err_count_nxt = err_base + ERR_CNT_W'(1);
            locked_nxt   = 1'b0;
            state_nxt    = ST_SYNC;
            sync_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt  = ST_IDLE;
          locked_nxt = 1'b0;
        end
      endcase
    end

    expected_nxt = (state_nxt == ST_IDLE) ? '0 : prev_nxt + WIDTH'(1);
  end

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker: directed scenarios plus randomized
// counter traffic, compared every cycle against a sequence-level reference model.
module tb_counter_checker;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned ERR_CNT_W  = 2;
  localparam int unsigned WRAP_CNT_W = 8;
  localparam int unsigned SYNC_LEN   = 2;
  localparam int MODV = 1 << WIDTH;
  localparam int ERR_MAX = (1 << ERR_CNT_W) - 1;
  localparam int WRAP_MOD = 1 << WRAP_CNT_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en = 1'b0;
  logic                  clr_stats = 1'b0;
  logic [WIDTH-1:0]      q_in = '0;
  logic                  locked;
  logic                  err;
  logic [ERR_CNT_W-1:0]  err_count;
  logic [WRAP_CNT_W-1:0] wrap_count;
  logic [WIDTH-1:0]      expected;

  int checks = 0;
  int errors = 0;

  counter_checker #(
    .WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W), .WRAP_CNT_W(WRAP_CNT_W), .SYNC_LEN(SYNC_LEN)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr_stats(clr_stats), .q_in(q_in),
    .locked(locked), .err(err), .err_count(err_count), .wrap_count(wrap_count),
    .expected(expected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: "watching" means a prior enabled sample exists to step from;
  // "run" counts consecutive good steps seen while hunting for lock.
  bit m_started = 0;
  bit m_watching, m_locked, m_err;
  int m_prev, m_run, m_errs, m_wraps;

  always @(posedge clk) begin
    bit r, e, c;
    int q;
    bit good;
    r = rst; e = en; c = clr_stats; q = int'(q_in);
    if (r) begin
      m_started = 1; m_watching = 0; m_locked = 0; m_err = 0;
      m_prev = 0; m_run = 0; m_errs = 0; m_wraps = 0;
    end else if (m_started) begin
      m_err = 0;
      if (c) begin m_errs = 0; m_wraps = 0; end
      if (!e) begin
        m_watching = 0; m_locked = 0;
      end else if (!m_watching) begin
        m_watching = 1; m_prev = q; m_run = 0;
      end else begin
        good = (q == (m_prev + 1) % MODV);
        if (m_locked) begin
          if (good) begin
            if (m_prev == MODV - 1) m_wraps = (m_wraps + 1) % WRAP_MOD;
          end else begin
            m_err = 1;
            m_errs = (m_errs < ERR_MAX) ? m_errs + 1 : ERR_MAX;
            m_locked = 0; m_run = 0;
          end
        end else begin
          m_run = good ? m_run + 1 : 0;
          if (m_run >= SYNC_LEN) begin m_locked = 1; m_run = 0; end
        end
        m_prev = q;
      end
    end
    #1;
    if (m_started) begin
      chk("model_locked", int'(locked), int'(m_locked));
      chk("model_err", int'(err), int'(m_err));
      chk("model_err_count", int'(err_count), m_errs);
      chk("model_wrap_count", int'(wrap_count), m_wraps);
      chk("model_expected", int'(expected), m_watching ? (m_prev + 1) % MODV : 0);
    end
  end

  // One sample: inputs change on the falling edge, returns just after the rising edge.
  task automatic cyc(input bit r, input bit e, input bit c, input int q);
    @(negedge clk);
    rst = r; en = e; clr_stats = c; q_in = WIDTH'(q);
    @(posedge clk);
    #2;
  endtask

  int v;
  int pulses;

  task automatic count_to(input int target);
    while (v != target) begin
      v = (v + 1) % MODV;
      cyc(0, 1, 0, v);
    end
  endtask

  initial begin
    // 1. Reset with garbage on the bus
    cyc(1, 0, 0, 7);
    cyc(1, 1, 0, 7);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_wrap_count", int'(wrap_count), 0);
    chk("rst_expected", int'(expected), 0);

    // 2. Lock on 0,1,2
    v = 0; cyc(0, 1, 0, 0);
    chk("sync_expected", int'(expected), 1);
    chk("sync_locked", int'(locked), 0);
    count_to(1);
    chk("sync1_locked", int'(locked), 0);
    count_to(2);
    chk("lock_locked", int'(locked), 1);
    chk("lock_expected", int'(expected), 3);

    // 3. Wrap counting
    count_to(15);
    chk("prewrap_wrap", int'(wrap_count), 0);
    count_to(0);
    chk("wrap1", int'(wrap_count), 1);
    for (int i = 0; i < 32; i++) begin v = (v + 1) % MODV; cyc(0, 1, 0, v); end
    chk("wrap3", int'(wrap_count), 3);
    chk("wrap_err_count", int'(err_count), 0);

    // 4. Skip a value
    count_to(6);
    cyc(0, 1, 0, 7);
    cyc(0, 1, 0, 9);
    chk("skip_err", int'(err), 1);
    chk("skip_err_count", int'(err_count), 1);
    chk("skip_locked", int'(locked), 0);
    cyc(0, 1, 0, 10);
    chk("skip_err_pulse", int'(err), 0);
    chk("skip_sync_locked", int'(locked), 0);
    cyc(0, 1, 0, 11);
    chk("skip_relock", int'(locked), 1);
    v = 11;

    // 5. Stuck bus
    cyc(0, 1, 1, 12); v = 12;
    chk("clr_err_count", int'(err_count), 0);
    chk("clr_wrap_count", int'(wrap_count), 0);
    count_to(4);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 5);
      pulses += int'(err);
      if (i > 0) chk("stuck_locked", int'(locked), 0);
    end
    chk("stuck_pulses", pulses, 1);
    chk("stuck_err_count", int'(err_count), 1);
    cyc(0, 1, 0, 6);
    cyc(0, 1, 0, 7);
    chk("stuck_relock", int'(locked), 1);
    v = 7;

    // 6. Saturation, clear-with-error, disable
    for (int k = 0; k < 5; k++) begin
      v = (v + 5) % MODV; cyc(0, 1, 0, v);
      count_to((v + 2) % MODV);
    end
    chk("sat_err_count", int'(err_count), 3);
    chk("sat_locked", int'(locked), 1);
    v = (v + 3) % MODV; cyc(0, 1, 1, v);
    chk("clr_mismatch_err_count", int'(err_count), 1);
    chk("clr_mismatch_err", int'(err), 1);
    count_to((v + 2) % MODV);
    cyc(0, 0, 0, (v + 1) % MODV);
    chk("dis_locked", int'(locked), 0);
    chk("dis_expected", int'(expected), 0);
    chk("dis_err_count", int'(err_count), 1);

    // Reset while locked
    v = 0; cyc(0, 1, 0, 0); count_to(3);
    chk("pre_rst_locked", int'(locked), 1);
    cyc(1, 1, 0, 4);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_err_count", int'(err_count), 0);
    chk("midrst_expected", int'(expected), 0);

    // Randomized traffic against the model
    v = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, e, c;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 99) >= 4);
      c = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) < 88) v = (v + 1) % MODV;
      else v = $urandom_range(0, MODV - 1);
      cyc(r, e, c, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
